// File: rtl/mux_scan_if.sv
// -----------------------------------------------------------------------------
// mux_scan_if
// Bundles the channel data, the selection controls and the registered results
// of mux_scan into one interface.
//   in        : CH*W packed channel data, channel k at [k*W +: W]
//   mode      : 0 = manual select, 1 = auto-scan
//   sel       : channel index used in manual mode
//   en        : scan enable mask, bit k includes channel k in the scan
//   dwell     : extra cycles spent on each channel while scanning
//   out       : registered data of the selected channel
//   out_sel   : registered index of the channel driving out
//   out_valid : out/out_sel carry a valid selection
//   wrap      : one-cycle pulse when the scan index wraps
// Modports: master drives the controls, slave is the mux itself.
// -----------------------------------------------------------------------------
interface mux_scan_if #(
  parameter int CH = 16,
  parameter int W  = 1
);
  localparam int SW = $clog2(CH);

  logic [CH*W-1:0] in;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [CH-1:0]   en;
  logic [7:0]      dwell;
  logic [W-1:0]    out;
  logic [SW-1:0]   out_sel;
  logic            out_valid;
  logic            wrap;

  modport master (
    output in, mode, sel, en, dwell,
    input  out, out_sel, out_valid, wrap
  );

  modport slave (
    input  in, mode, sel, en, dwell,
    output out, out_sel, out_valid, wrap
  );
endinterface

// File: rtl/mux_scan.sv
// -----------------------------------------------------------------------------
// mux_scan
// Channel multiplexer with a manual mode (out follows sel) and an auto-scan
// mode that walks the enabled channels, staying dwell+1 cycles on each.
// An all-zero enable mask in scan mode parks the block in HALT with the last
// output held and out_valid low.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : mux_scan_if slave modport (data, controls and registered results)
// -----------------------------------------------------------------------------
module mux_scan #(
  parameter int CH = 16,
  parameter int W  = 1
) (
  input  logic        clk,
  input  logic        rst,
  mux_scan_if.slave   bus
);
  localparam int SW = $clog2(CH);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_SCAN   = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  out_q, out_d;
  logic [SW-1:0] out_sel_q, out_sel_d;
  logic          out_valid_q, out_valid_d;
  logic          wrap_q, wrap_d;
  logic [SW-1:0] cur_q, cur_d;
  logic [7:0]    count_q, count_d;

  logic [SW-1:0] first_en_s;
  logic [SW-1:0] next_en_s;

  // Lowest-indexed set bit of the mask; 0 when the mask is empty.
  function automatic logic [SW-1:0] lowest_set(input logic [CH-1:0] mask);
    logic [SW-1:0] idx;
    idx = {SW{1'b0}};
    // Descending walk so the lowest set bit is written last.
    for (int k = CH - 1; k >= 0; k--) begin
      if (mask[k]) idx = SW'(k);
      else         idx = idx;
    end
    return idx;
  endfunction

  // First set bit searching upward from base+1, wrapping modulo CH.
  // Offset CH aliases to base itself, so a lone enabled channel finds itself.
  function automatic logic [SW-1:0] next_after(input logic [CH-1:0] mask,
                                               input logic [SW-1:0] base);
    logic [SW-1:0] idx;
    logic [SW-1:0] cand;
    idx = base;
    for (int i = CH; i >= 1; i--) begin
      cand = base + SW'(i);
      if (mask[cand]) idx = cand;
      else            idx = idx;
    end
    return idx;
  endfunction

  // Slice one channel out of the packed data bus.
  function automatic logic [W-1:0] chan(input logic [CH*W-1:0] data,
                                        input logic [SW-1:0]   idx);
    return data[int'(idx)*W +: W];
  endfunction

  // Channel search results, evaluated every cycle in a single pass.
  always_comb begin
    first_en_s = lowest_set(bus.en);
    next_en_s  = next_after(bus.en, cur_q);
  end

  // Next-state and next-output logic for all three states.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    wrap_d      = 1'b0;
    cur_d       = cur_q;
    count_d     = count_q;

    if (!bus.mode) begin
      state_d     = ST_MANUAL;
      out_d       = chan(bus.in, bus.sel);
      out_sel_d   = bus.sel;
      out_valid_d = 1'b1;
      count_d     = 8'd0;
    end else if (bus.en == {CH{1'b0}}) begin
      // Outputs keep their last values; only validity drops.
      state_d     = ST_HALT;
      out_valid_d = 1'b0;
      count_d     = 8'd0;
    end else begin
      state_d = ST_SCAN;
      case (state_q)
        ST_SCAN: begin
          // >= rather than == so a dwell lowered below count advances at once.
          if (!bus.en[cur_q] || (count_q >= bus.dwell)) begin
            cur_d   = next_en_s;
            count_d = 8'd0;
            wrap_d  = (next_en_s <= cur_q);
          end else begin
            count_d = count_q + 8'd1;
          end
        end
        default: begin
          // Entering the scan from MANUAL or HALT.
          cur_d   = first_en_s;
          count_d = 8'd0;
        end
      endcase
      // Data is taken live from the channel being shown this cycle.
      out_d       = chan(bus.in, cur_d);
      out_sel_d   = cur_d;
      out_valid_d = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_MANUAL;
      out_q       <= {W{1'b0}};
      out_sel_q   <= {SW{1'b0}};
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      cur_q       <= {SW{1'b0}};
      count_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
      cur_q       <= cur_d;
      count_q     <= count_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_mux_scan.sv
// -----------------------------------------------------------------------------
// tb_mux_scan
// Directed bench for mux_scan with CH=4, W=8 and channel data AA/BB/CC/DD.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_mux_scan;
  localparam int CH = 4;
  localparam int W  = 8;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  logic [7:0] chdat [4];

  mux_scan_if #(.CH(CH), .W(W)) bus ();

  mux_scan #(.CH(CH), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_data();
    bus.in = {chdat[3], chdat[2], chdat[1], chdat[0]};
  endtask

  int exp_sel32 [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int exp_sel33 [5] = '{1, 3, 1, 3, 1};
  int exp_wr33  [5] = '{0, 0, 1, 0, 1};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chdat[0] = 8'hAA; chdat[1] = 8'hBB; chdat[2] = 8'hCC; chdat[3] = 8'hDD;
    load_data();
    rst       = 1'b1;
    bus.mode  = 1'b0;
    bus.sel   = 2'd2;
    bus.en    = 4'b0000;
    bus.dwell = 8'd0;

    // Reset held two cycles
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq($sformatf("rst_out_%0d", i), 32'(bus.out), 32'h0);
      check_eq($sformatf("rst_valid_%0d", i), 32'(bus.out_valid), 32'h0);
    end
    check_eq("rst_sel", 32'(bus.out_sel), 32'h0);
    check_eq("rst_wrap", 32'(bus.wrap), 32'h0);

    // Release: manual output on the first edge
    rst = 1'b0;
    tick();
    check_eq("man_out", 32'(bus.out), 32'hCC);
    check_eq("man_sel", 32'(bus.out_sel), 32'd2);
    check_eq("man_valid", 32'(bus.out_valid), 32'd1);
    check_eq("man_wrap", 32'(bus.wrap), 32'd0);
    bus.sel = 2'd3;
    tick();
    check_eq("man_out3", 32'(bus.out), 32'hDD);
    check_eq("man_sel3", 32'(bus.out_sel), 32'd3);

    // Full-mask scan with dwell 1
    bus.mode  = 1'b1;
    bus.en    = 4'b1111;
    bus.dwell = 8'd1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check_eq($sformatf("scan_sel_%0d", i), 32'(bus.out_sel), 32'(exp_sel32[i]));
      check_eq($sformatf("scan_out_%0d", i), 32'(bus.out), 32'(chdat[exp_sel32[i]]));
      check_eq($sformatf("scan_wrap_%0d", i), 32'(bus.wrap), (i == 8) ? 32'd1 : 32'd0);
      check_eq($sformatf("scan_valid_%0d", i), 32'(bus.out_valid), 32'd1);
    end

    // Masked scan, dwell 0
    bus.en    = 4'b1010;
    bus.dwell = 8'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("mask_sel_%0d", i), 32'(bus.out_sel), 32'(exp_sel33[i]));
      check_eq($sformatf("mask_out_%0d", i), 32'(bus.out), 32'(chdat[exp_sel33[i]]));
      check_eq($sformatf("mask_wrap_%0d", i), 32'(bus.wrap), 32'(exp_wr33[i]));
    end

    // Park on channel 2 with dwell 5, then let count reach 1
    bus.en    = 4'b0100;
    bus.dwell = 8'd5;
    tick();
    check_eq("park_sel", 32'(bus.out_sel), 32'd2);
    tick();
    check_eq("park_sel_hold", 32'(bus.out_sel), 32'd2);
    // Current channel drops out of the mask
    bus.en = 4'b0001;
    tick();
    check_eq("drop_sel", 32'(bus.out_sel), 32'd0);
    check_eq("drop_out", 32'(bus.out), 32'hAA);
    check_eq("drop_wrap", 32'(bus.wrap), 32'd1);
    // Single channel: wrap every dwell+1 = 6 cycles
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq($sformatf("single_wrap_%0d", i), 32'(bus.wrap), (i % 6 == 5) ? 32'd1 : 32'd0);
      check_eq($sformatf("single_sel_%0d", i), 32'(bus.out_sel), 32'd0);
    end

    // Halt and recovery
    bus.en = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq($sformatf("halt_valid_%0d", i), 32'(bus.out_valid), 32'd0);
      check_eq($sformatf("halt_out_%0d", i), 32'(bus.out), 32'hAA);
      check_eq($sformatf("halt_sel_%0d", i), 32'(bus.out_sel), 32'd0);
      check_eq($sformatf("halt_wrap_%0d", i), 32'(bus.wrap), 32'd0);
    end
    bus.en = 4'b1000;
    tick();
    check_eq("resume_sel", 32'(bus.out_sel), 32'd3);
    check_eq("resume_out", 32'(bus.out), 32'hDD);
    check_eq("resume_valid", 32'(bus.out_valid), 32'd1);

    // Live data while scanning, then mode back to manual mid-dwell
    bus.en    = 4'b1111;
    bus.dwell = 8'd3;
    tick();
    check_eq("live_sel", 32'(bus.out_sel), 32'd3);
    chdat[3] = 8'h5A;
    load_data();
    tick();
    check_eq("live_out", 32'(bus.out), 32'h5A);
    chdat[3] = 8'hDD;
    load_data();
    bus.mode = 1'b0;
    bus.sel  = 2'd1;
    tick();
    check_eq("m2man_out", 32'(bus.out), 32'hBB);
    check_eq("m2man_sel", 32'(bus.out_sel), 32'd1);
    check_eq("m2man_valid", 32'(bus.out_valid), 32'd1);

    // Reset mid-scan
    bus.mode  = 1'b1;
    bus.en    = 4'b0110;
    bus.dwell = 8'd5;
    tick();
    check_eq("pre_rst_sel", 32'(bus.out_sel), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check_eq("mrst_out", 32'(bus.out), 32'h0);
    check_eq("mrst_sel", 32'(bus.out_sel), 32'h0);
    check_eq("mrst_valid", 32'(bus.out_valid), 32'h0);
    check_eq("mrst_wrap", 32'(bus.wrap), 32'h0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_sel", 32'(bus.out_sel), 32'd1);
    check_eq("post_rst_out", 32'(bus.out), 32'hBB);
    check_eq("post_rst_valid", 32'(bus.out_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
